range_sequencer: RTL and testbench

Sequencing controller for the range-finder datapath. Accepts a window length and a start command, feeds a gapped sample stream into the finder with correctly placed `go`/`finish` pulses, then waits the finder's result latency and captures the range. It also collects finder and protocol errors into a sticky status flag. The block sits between the chip I/O sample source and the range-finder instance; it owns every finder control input.

---
 rtl/range_sequencer.sv | 138 +++++++++++++
 tb/tb_range_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_sequencer.sv
// Sequencer that owns the range-finder controls: frames a gapped sample window with
// go/finish pulses, waits out the finder latency, captures the range and tracks errors.
module range_sequencer #(
  parameter int WIDTH      = 10,
  parameter int CNT_W      = 8,
  parameter int RESULT_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             abort,
  input  logic             smp_valid,
  input  logic [WIDTH-1:0] smp_data,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             err
);

  localparam int LAT_W = (RESULT_LAT < 2) ? 1 : $clog2(RESULT_LAT + 1);

  typedef enum logic [2:0] {IDLE, FIRST, RUN, WAIT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
  logic [WIDTH-1:0] rf_data_reg, rf_data_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             rf_go_reg, rf_go_next;
  logic             rf_finish_reg, rf_finish_next;
  logic             result_valid_reg, result_valid_next;
  logic             err_reg, err_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      remaining_reg    <= '0;
      lat_cnt_reg      <= '0;
      rf_data_reg      <= '0;
      result_reg       <= '0;
      rf_go_reg        <= 1'b0;
      rf_finish_reg    <= 1'b0;
      result_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      remaining_reg    <= remaining_next;
      lat_cnt_reg      <= lat_cnt_next;
      rf_data_reg      <= rf_data_next;
      result_reg       <= result_next;
      rf_go_reg        <= rf_go_next;
      rf_finish_reg    <= rf_finish_next;
      result_valid_reg <= result_valid_next;
      err_reg          <= err_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    remaining_next    = remaining_reg;
    lat_cnt_next      = lat_cnt_reg;
    rf_data_next      = rf_data_reg;
    result_next       = result_reg;
    rf_go_next        = 1'b0;
    rf_finish_next    = 1'b0;
    result_valid_next = 1'b0;
    err_next          = err_reg;

    if (rf_error && state_reg != IDLE) err_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (win_len >= CNT_W'(2)) begin
            state_next     = FIRST;
            remaining_next = win_len;
            err_next       = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      FIRST: begin
        if (abort) begin
          state_next = IDLE;
        end else if (smp_valid) begin
          rf_data_next   = smp_data;
          rf_go_next     = 1'b1;
          remaining_next = remaining_reg - CNT_W'(1);
          state_next     = RUN;
        end
      end
      RUN: begin
        // An aborted window is still closed with finish; DONE gives it one busy cycle.
        if (abort) begin
          rf_finish_next = 1'b1;
          state_next     = DONE;
        end else if (smp_valid) begin
          rf_data_next = smp_data;
          if (remaining_reg != '0) remaining_next = remaining_reg - CNT_W'(1);
          if (remaining_reg <= CNT_W'(1)) begin
            rf_finish_next = 1'b1;
            lat_cnt_next   = '0;
            state_next     = WAIT;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (lat_cnt_reg == LAT_W'(RESULT_LAT)) begin
          result_next       = rf_range;
          result_valid_next = 1'b1;
          state_next        = DONE;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rf_data      = rf_data_reg;
  assign rf_go        = rf_go_reg;
  assign rf_finish    = rf_finish_reg;
  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign err          = err_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_range_sequencer.sv
// Bench for range_sequencer: one instance with RESULT_LAT=1 and one with RESULT_LAT=3, each
// driving a max-min finder model; expected captures go through a cycle-stamped scoreboard.
module tb_range_sequencer;

  localparam logic [9:0] POISON = 10'h3FF;

  logic       clock = 1'b0;
  logic       reset, start, abort, smp_valid, rf_error, sel;
  logic [7:0] win_len;
  logic [9:0] smp_data;

  logic [9:0] d_rf_data [2];
  logic [9:0] d_rf_range [2];
  logic [9:0] d_result [2];
  logic       d_rf_go [2];
  logic       d_rf_finish [2];
  logic       d_busy [2];
  logic       d_result_valid [2];
  logic       d_err [2];

  always #5 clock = ~clock;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;
      localparam bit ME  = (gi == 1);
      logic [9:0] lo, hi, lo_r, hi_r;
      logic [9:0] pipe [LAT];

      range_sequencer #(.WIDTH(10), .CNT_W(8), .RESULT_LAT(LAT)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start && (sel == ME)),
        .win_len     (win_len),
        .abort       (abort && (sel == ME)),
        .smp_valid   (smp_valid && (sel == ME)),
        .smp_data    (smp_data),
        .rf_data     (d_rf_data[gi]),
        .rf_go       (d_rf_go[gi]),
        .rf_finish   (d_rf_finish[gi]),
        .rf_range    (d_rf_range[gi]),
        .rf_error    (rf_error && (sel == ME)),
        .busy        (d_busy[gi]),
        .result      (d_result[gi]),
        .result_valid(d_result_valid[gi]),
        .err         (d_err[gi])
      );

      // Finder model: max-min over go..finish, valid for exactly one cycle LAT cycles after finish.
      always_comb begin
        lo = d_rf_data[gi];
        hi = d_rf_data[gi];
        if (!d_rf_go[gi]) begin
          if (lo_r < lo) lo = lo_r;
          if (hi_r > hi) hi = hi_r;
        end
      end
      always @(posedge clock) begin
        lo_r    <= lo;
        hi_r    <= hi;
        pipe[0] <= d_rf_finish[gi] ? (hi - lo) : POISON;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign d_rf_range[gi] = pipe[LAT-1];
    end
  endgenerate

  logic [9:0] o_rf_data, o_result;
  logic       o_rf_go, o_rf_finish, o_busy, o_rv, o_err;
  assign o_rf_data   = d_rf_data[sel];
  assign o_result    = d_result[sel];
  assign o_rf_go     = d_rf_go[sel];
  assign o_rf_finish = d_rf_finish[sel];
  assign o_busy      = d_busy[sel];
  assign o_rv        = d_result_valid[sel];
  assign o_err       = d_err[sel];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    int value;
    int cycle;
  } exp_t;
  exp_t sb_q[$];

  typedef struct packed {
    logic             sel;
    logic [7:0]       win_len;
    logic [3:0]       n;
    logic [5:0][10:0] stream;   // {valid, sample} per cycle
    int               rferr_at; // stream slot carrying rf_error, -1 for none
    logic             hold;     // keep start high while the window runs
    logic [9:0]       exp_range;
    logic             exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    while (sb_q.size() > 0 && sb_q[0].cycle < cyc) begin
      e = sb_q.pop_front();
      chk("result_valid_missed", cyc, e.cycle);
    end
    if (sb_q.size() > 0 && sb_q[0].cycle == cyc) begin
      e = sb_q.pop_front();
      chk("result_valid", int'(o_rv), 1);
      chk("result", int'(o_result), e.value);
      $display("cycle %0d: result_valid result=%0d expected %0d", cyc, o_result, e.value);
    end else if (o_rv) begin
      chk("result_valid_unexpected", int'(o_rv), 0);
    end
  endtask

  function automatic vec_t mkvec(input logic s, input int wl, input int n,
                                 input int s0, input int s1, input int s2,
                                 input int s3, input int s4, input int s5,
                                 input int rferr, input logic hold,
                                 input int rng, input logic e);
    vec_t v;
    int   sm [6];
    sm = '{s0, s1, s2, s3, s4, s5};
    v.sel      = s;
    v.win_len  = 8'(wl);
    v.n        = 4'(n);
    for (int i = 0; i < 6; i++) v.stream[i] = (sm[i] < 0) ? 11'd0 : {1'b1, 10'(sm[i])};
    v.rferr_at  = rferr;
    v.hold      = hold;
    v.exp_range = 10'(rng);
    v.exp_err   = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    int         lat;
    int         acc;
    int         f;
    int         k;
    logic       vld;
    logic [9:0] last;
    lat  = v.sel ? 3 : 1;
    acc  = 0;
    f    = 0;
    last = '0;
    start   = 1'b1;
    win_len = v.win_len;
    tick();
    start = v.hold;
    chk("busy_after_start", int'(o_busy), 1);
    chk("err_cleared_by_start", int'(o_err), 0);
    for (int i = 0; i < int'(v.n); i++) begin
      vld       = v.stream[i][10];
      smp_valid = vld;
      smp_data  = v.stream[i][9:0];
      rf_error  = (i == v.rferr_at);
      if (vld) begin
        acc++;
        last = v.stream[i][9:0];
        if (acc == int'(v.win_len)) f = cyc;
      end
      tick();
      smp_valid = 1'b0;
      rf_error  = 1'b0;
      if (acc > 0) chk("rf_data", int'(o_rf_data), int'(last));
      chk("rf_go", int'(o_rf_go), int'(vld && acc == 1));
      chk("rf_finish", int'(o_rf_finish), int'(vld && acc == int'(v.win_len)));
      if (v.rferr_at >= 0 && i >= v.rferr_at) chk("err_sticky", int'(o_err), 1);
    end
    start = 1'b0;
    sb_q.push_back('{value: int'(v.exp_range), cycle: f + 2 + lat});
    k = 0;
    while (o_busy && k < 20) begin
      tick();
      k++;
      chk("no_extra_pulse", int'(o_rf_finish | o_rf_go), 0);
    end
    chk("idle_cycle", cyc, f + 3 + lat);
    chk("err_at_end", int'(o_err), int'(v.exp_err));
    $display("window len=%0d lat=%0d: last sample cycle %0d, idle at %0d", v.win_len, lat, f, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mkvec(0, 4, 4,  5,  9,  2,  7,  0,  0, -1, 0,  7, 0);
    vecs[1] = mkvec(0, 3, 6, 10, -1, -1,  3, -1,  6, -1, 0,  7, 0);
    vecs[2] = mkvec(0, 4, 5,  4, 12, -1,  1,  6,  0,  2, 1, 11, 1);
    vecs[3] = mkvec(0, 2, 2,  3, 20,  0,  0,  0,  0, -1, 0, 17, 0);
    vecs[4] = mkvec(1, 3, 3,  1,  5,  3,  0,  0,  0, -1, 0,  4, 0);
    vecs[5] = mkvec(1, 3, 4,  6, -1,  2,  9,  0,  0, -1, 0,  7, 0);

    sel = 1'b0; reset = 1'b1; start = 1'b0; abort = 1'b0;
    smp_valid = 1'b0; rf_error = 1'b0; win_len = '0; smp_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_rf_data", int'(o_rf_data), 0);
    chk("reset_rf_go", int'(o_rf_go), 0);
    chk("reset_rf_finish", int'(o_rf_finish), 0);
    chk("reset_result", int'(o_result), 0);
    chk("reset_result_valid", int'(o_rv), 0);
    chk("reset_err", int'(o_err), 0);

    // Short windows are rejected: err set, no busy, no go.
    start = 1'b1; win_len = 8'd1;
    tick();
    start = 1'b0;
    chk("len1_busy", int'(o_busy), 0);
    chk("len1_err", int'(o_err), 1);
    tick();
    chk("len1_go", int'(o_rf_go), 0);
    chk("len1_busy_later", int'(o_busy), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_clears_err", int'(o_err), 0);
    start = 1'b1; win_len = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", int'(o_busy), 0);
    chk("len0_err", int'(o_err), 1);
    tick();
    chk("len0_go", int'(o_rf_go), 0);
    $display("invalid-length starts done at cycle %0d", cyc);

    for (int i = 0; i < 4; i++) drive(vecs[i]);

    // Abort in RUN after two of five samples; the concurrent sample must be dropped.
    start = 1'b1; win_len = 8'd5;
    tick();
    start = 1'b0;
    smp_valid = 1'b1; smp_data = 10'd11;
    tick();
    smp_data = 10'd13;
    tick();
    abort = 1'b1; smp_data = 10'd50;
    tick();
    abort = 1'b0; smp_valid = 1'b0;
    chk("abort_run_finish", int'(o_rf_finish), 1);
    chk("abort_run_data", int'(o_rf_data), 13);
    chk("abort_run_go", int'(o_rf_go), 0);
    tick();
    chk("abort_run_idle", int'(o_busy), 0);
    chk("abort_run_finish_once", int'(o_rf_finish), 0);
    repeat (5) tick();
    chk("abort_run_result_held", int'(o_result), 17);
    $display("abort in RUN done at cycle %0d", cyc);

    // Abort in FIRST: no go, sample not taken.
    start = 1'b1; win_len = 8'd3;
    tick();
    start = 1'b0; abort = 1'b1; smp_valid = 1'b1; smp_data = 10'd40;
    tick();
    abort = 1'b0; smp_valid = 1'b0;
    chk("abort_first_idle", int'(o_busy), 0);
    chk("abort_first_go", int'(o_rf_go), 0);
    chk("abort_first_data", int'(o_rf_data), 13);
    $display("abort in FIRST done at cycle %0d", cyc);

    // Abort in WAIT: finder still produces a range, but it must not be captured.
    start = 1'b1; win_len = 8'd2;
    tick();
    start = 1'b0; smp_valid = 1'b1; smp_data = 10'd30;
    tick();
    smp_data = 10'd31;
    tick();
    smp_valid = 1'b0;
    chk("wait_finish", int'(o_rf_finish), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_wait_idle", int'(o_busy), 0);
    repeat (4) tick();
    chk("abort_wait_result_held", int'(o_result), 17);
    $display("abort in WAIT done at cycle %0d", cyc);

    // Reset in RUN: everything back to zero, no finish.
    start = 1'b1; win_len = 8'd4;
    tick();
    start = 1'b0; smp_valid = 1'b1; smp_data = 10'd7;
    tick();
    smp_data = 10'd8;
    tick();
    reset = 1'b1; smp_data = 10'd9;
    tick();
    reset = 1'b0; smp_valid = 1'b0;
    chk("midreset_busy", int'(o_busy), 0);
    chk("midreset_rf_data", int'(o_rf_data), 0);
    chk("midreset_rf_go", int'(o_rf_go), 0);
    chk("midreset_rf_finish", int'(o_rf_finish), 0);
    chk("midreset_result", int'(o_result), 0);
    chk("midreset_err", int'(o_err), 0);
    tick();
    chk("midreset_no_finish", int'(o_rf_finish), 0);
    $display("reset in RUN done at cycle %0d", cyc);

    sel = 1'b1;
    for (int i = 4; i < 6; i++) drive(vecs[i]);

    repeat (3) tick();
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
